// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Holds the FSM state type, the write-port priority constant and the address-width helper.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    // Write port that wins a same-address collision (and the bypass)
    localparam int unsigned WINNING_WPORT = 1;
    localparam int unsigned LOSING_WPORT  = 1 - WINNING_WPORT;

    function automatic int unsigned rf_addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of regfile_mp.
// Selects the bypassed write data or the array entry, then applies the zero-register force.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_i,
    input  logic [AW-1:0]        raddr_i,
    input  logic [WIDTH-1:0]     entry_i,
    input  logic [1:0]           we_i,
    input  logic [2*AW-1:0]      waddr_i,
    input  logic [2*WIDTH-1:0]   wdata_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] rdata_q, rdata_d;

    // we_i is already masked for collisions, so the winner is checked last and overrides
    always_comb begin
        rdata_d = entry_i;
        if (we_i[LOSING_WPORT] && (waddr_i[LOSING_WPORT*AW +: AW] == raddr_i)) begin
            rdata_d = wdata_i[LOSING_WPORT*WIDTH +: WIDTH];
        end
        if (we_i[WINNING_WPORT] && (waddr_i[WINNING_WPORT*AW +: AW] == raddr_i)) begin
            rdata_d = wdata_i[WINNING_WPORT*WIDTH +: WIDTH];
        end
        if (ZERO_REG && (raddr_i == '0)) begin
            rdata_d = '0;
        end
        if (!run_i) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two write ports, NR registered read ports with bypass,
// optional hardwired zero entry and a post-reset clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NR       = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [1:0]                              we,
    input  logic [2*regfile_pkg::rf_addr_width(DEPTH)-1:0] waddr,
    input  logic [2*WIDTH-1:0]                      wdata,
    input  logic [NR*regfile_pkg::rf_addr_width(DEPTH)-1:0] raddr,
    output logic [NR*WIDTH-1:0]                     rdata,
    output logic                                    busy
);

    localparam int unsigned AW = rf_addr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    rf_state_t        state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             busy_q;
    logic             run;

    logic [AW-1:0]    wa [2];
    logic [WIDTH-1:0] wd [2];
    logic [1:0]       we_ok, we_eff;

    assign run = (state_q == RUN);

    // Resolve writes once so the array and every bypass mux agree on the winner
    always_comb begin
        we_eff = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            wa[p]    = waddr[p*AW +: AW];
            wd[p]    = wdata[p*WIDTH +: WIDTH];
            we_ok[p] = run && we[p] && !(ZERO_REG && (wa[p] == '0));
        end
        we_eff = we_ok;
        if (we_ok[WINNING_WPORT] && we_ok[LOSING_WPORT] && (wa[0] == wa[1])) begin
            we_eff[LOSING_WPORT] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == CLEAR) begin
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d == CLEAR);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_q[idx_q] <= '0;
            end else begin
                for (int unsigned p = 0; p < 2; p++) begin
                    if (we_eff[p]) begin
                        mem_q[wa[p]] <= wd[p];
                    end
                end
            end
        end
    end

    assign busy = busy_q;

    for (genvar r = 0; r < NR; r++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr[r*AW +: AW];

        regfile_read_port #(
            .WIDTH    (WIDTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .clk     (clk),
            .reset   (reset),
            .run_i   (run),
            .raddr_i (ra),
            .entry_i (mem_q[ra]),
            .we_i    (we_eff),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .rdata_o (rdata[r*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear timing, write/read, collision, bypass,
// zero register (both settings), multi-port reads and reset during clear.
module tb_regfile_mp;

    localparam int unsigned W   = 32;
    localparam int unsigned D   = 32;
    localparam int unsigned NRP = 4;
    localparam int unsigned AW  = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         we;
    logic [2*AW-1:0]    waddr;
    logic [2*W-1:0]     wdata;
    logic [NRP*AW-1:0]  raddr;
    logic [NRP*W-1:0]   rdata;
    logic               busy;
    logic [W-1:0]       rdata_z;
    logic               busy_z;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .WIDTH    (W),
        .DEPTH    (D),
        .NR       (NRP),
        .ZERO_REG (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata),
        .busy  (busy)
    );

    regfile_mp #(
        .WIDTH    (W),
        .DEPTH    (D),
        .NR       (1),
        .ZERO_REG (1'b0)
    ) dut_z0 (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr[AW-1:0]),
        .rdata (rdata_z),
        .busy  (busy_z)
    );

    typedef struct {
        logic [1:0]           we;
        logic [4:0]           wa0;
        logic [31:0]          wd0;
        logic [4:0]           wa1;
        logic [31:0]          wd1;
        logic [3:0][4:0]      ra;
        logic [3:0][31:0]     ex;
        logic [3:0]           mask;
        logic                 chkz;
        logic [31:0]          exz;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] we_v, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1, input logic [19:0] ra,
                                input logic [127:0] ex, input logic [3:0] mask, input logic chkz,
                                input logic [31:0] exz);
        vec_t v;
        v.we = we_v; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ra = ra; v.ex = ex; v.mask = mask; v.chkz = chkz; v.exz = exz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    vec_t vecs [12];
    int   cnt;

    initial begin
        // ra packs {port3, port2, port1, port0}; ex likewise
        vecs[0]  = mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, {5'd9, 5'd9, 5'd9, 5'd9},
                      {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0001, 1'b0, 32'h0);
        vecs[1]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, {5'd9, 5'd9, 5'd9, 5'd5},
                      {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 4'b0001, 1'b0, 32'h0);
        vecs[2]  = mk(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, {5'd9, 5'd9, 5'd7, 5'd5},
                      {32'h0, 32'h0, 32'h22222222, 32'hDEADBEEF}, 4'b0011, 1'b0, 32'h0);
        vecs[3]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, {5'd9, 5'd9, 5'd7, 5'd7},
                      {32'h0, 32'h0, 32'h22222222, 32'h22222222}, 4'b0011, 1'b0, 32'h0);
        vecs[4]  = mk(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, {5'd9, 5'd9, 5'd9, 5'd0},
                      {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0001, 1'b1, 32'hFFFFFFFF);
        vecs[5]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, {5'd9, 5'd9, 5'd9, 5'd0},
                      {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0001, 1'b1, 32'hFFFFFFFF);
        vecs[6]  = mk(2'b11, 5'd1, 32'h01010101, 5'd2, 32'h02020202, {5'd9, 5'd9, 5'd2, 5'd1},
                      {32'h0, 32'h0, 32'h02020202, 32'h01010101}, 4'b0011, 1'b0, 32'h0);
        vecs[7]  = mk(2'b01, 5'd31, 32'h31313131, 5'd0, 32'h0, {5'd31, 5'd2, 5'd1, 5'd1},
                      {32'h31313131, 32'h02020202, 32'h01010101, 32'h01010101}, 4'b1111, 1'b0, 32'h0);
        vecs[8]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, {5'd31, 5'd2, 5'd1, 5'd1},
                      {32'h31313131, 32'h02020202, 32'h01010101, 32'h01010101}, 4'b1111, 1'b0, 32'h0);
        vecs[9]  = mk(2'b10, 5'd5, 32'hABABABAB, 5'd0, 32'hFFFF0000, {5'd9, 5'd9, 5'd5, 5'd0},
                      {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, 4'b0011, 1'b1, 32'hFFFF0000);
        vecs[10] = mk(2'b11, 5'd0, 32'h12121212, 5'd9, 32'h99999999, {5'd9, 5'd9, 5'd9, 5'd0},
                      {32'h0, 32'h0, 32'h99999999, 32'h0}, 4'b0011, 1'b1, 32'h12121212);
        vecs[11] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, {5'd9, 5'd9, 5'd9, 5'd0},
                      {32'h0, 32'h0, 32'h99999999, 32'h0}, 4'b0011, 1'b1, 32'h12121212);

        reset = 1'b1; we = '0; waddr = '0; wdata = '0; raddr = '0;
        repeat (3) step();
        chk("reset_busy", {31'b0, busy}, 32'h1);
        chk("reset_busy_z0", {31'b0, busy_z}, 32'h1);
        for (int r = 0; r < NRP; r++) chk($sformatf("reset_rdata%0d", r), rdata[r*W +: W], 32'h0);

        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            cnt++;
            if (!busy) break;
        end
        chk("clear_len", 32'(cnt), 32'd32);

        for (int a = 0; a < 32; a++) begin
            for (int r = 0; r < NRP; r++) raddr[r*AW +: AW] = 5'((a + r) % 32);
            step();
            for (int r = 0; r < NRP; r++) chk($sformatf("cleared_a%0d_p%0d", a, r), rdata[r*W +: W], 32'h0);
        end

        for (int i = 0; i < 12; i++) begin
            we    = vecs[i].we;
            waddr = {vecs[i].wa1, vecs[i].wa0};
            wdata = {vecs[i].wd1, vecs[i].wd0};
            raddr = vecs[i].ra;
            step();
            for (int r = 0; r < NRP; r++) begin
                if (vecs[i].mask[r]) chk($sformatf("vec%0d_rd%0d", i, r), rdata[r*W +: W], vecs[i].ex[r]);
            end
            if (vecs[i].chkz) chk($sformatf("vec%0d_z0", i), rdata_z, vecs[i].exz);
        end
        we = '0;

        // Reset reasserted part-way through a clear, then writes held on throughout
        raddr = {4{5'd5}};
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (10) step();
        chk("midclear_busy_c10", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        step();
        chk("midclear_reset_busy", {31'b0, busy}, 32'h1);
        reset = 1'b0;
        we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'hA5A5A5A5};
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            cnt++;
            chk($sformatf("clear_rdata_e%0d", cnt), rdata[W-1:0], 32'h0);
            if (!busy) break;
        end
        chk("midclear_len", 32'(cnt), 32'd32);

        we = '0;
        raddr = {5'd9, 5'd7, 5'd5, 5'd3};
        step();
        chk("busy_write_dropped", rdata[0*W +: W], 32'h0);
        chk("recleared_a5", rdata[1*W +: W], 32'h0);
        chk("recleared_a7", rdata[2*W +: W], 32'h0);

        we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h12345678};
        raddr = {4{5'd4}};
        step();
        chk("first_write_bypass", rdata[0*W +: W], 32'h12345678);
        we = '0;
        step();
        chk("first_write_array", rdata[0*W +: W], 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: the successor to the single-write, dual-read 32×32 register file in the datapath. It adds configurable width, depth and read-port count, two write ports with defined collision priority, an optional hardwired zero register, and write-to-read bypass. A sequenced clear engine zeroes every entry after reset. It sits between decode and execute and feeds operand latches.

## Interface
- `WIDTH`, 32, data width in bits
- `DEPTH`, 32, number of entries (power of two, ≥2)
- `NR`, 2, number of read ports (1–4)
- `ZERO_REG`, 1, when 1, entry 0 reads as 0 and ignores writes
- `AW`, $clog2(DEPTH), derived address width (localparam)

Ports:
- `clk` input 1 clock, all state on rising edge
- `reset` input 1 reset, synchronous, active-high
- `we` input 2 write enables, bit p for write port p
- `waddr` input 2·AW write addresses, port p at [p·AW +: AW]
- `wdata` input 2·WIDTH write data, port p at [p·WIDTH +: WIDTH]
- `raddr` input NR·AW read addresses, port r at [r·AW +: AW]
- `rdata` output NR·WIDTH registered read data, port r at [r·WIDTH +: WIDTH]
- `busy` output 1 high while the clear engine runs; writes are ignored

## Operation
- FSM has two states, CLEAR and RUN. An edge with `reset`=1 forces CLEAR, sets clear index to 0 and sets all `rdata` to 0.
- CLEAR, non-reset edge: entry[idx]←0, idx←idx+1. If idx==DEPTH−1, the FSM moves to RUN. `we` is ignored. `rdata` stays 0.
- RUN: on each edge, port p writes wdata[p] to entry waddr[p] if we[p]=1.
- Collision: both ports enabled with the same address → port 1 wins. Port 0's data is discarded.
- ZERO_REG=1: writes to address 0 are dropped. Reads of address 0 return 0 regardless of stored contents or bypass.
- Reads in RUN are synchronous. rdata[r] is loaded with the content of raddr[r] on each edge.
- Bypass (write-first): if a write to raddr[r] occurs on the same edge, rdata[r] gets that write's data. Port 1 takes priority over port 0, matching the collision rule.
- Read ports are independent. Any number of ports may read the same address.

## Timing
- Reset values: `rdata`=0 on all ports, `busy`=1, state CLEAR, idx=0.
- `busy` is registered as (state==CLEAR). It stays high for exactly DEPTH edges after the first edge with `reset`=0, then falls.
- Reset asserted mid-clear restarts the clear from idx 0. The full DEPTH cycles are required again.
- Read latency is 1 cycle: raddr presented before edge N gives rdata valid after edge N.
- Write-to-read: a write on edge N is visible to a read on edge N through the bypass path. It is visible from the array on edge N+1 onward.
- The first write accepted is on the edge after `busy` falls. A `we` presented while busy=1 is lost, with no back-pressure beyond `busy`.
- No combinational path from any input to `rdata` or `busy`.

## Structure
- Shared package `regfile_pkg` holds:
  - FSM state typedef (`rf_state_t`: CLEAR, RUN)
  - the port-priority constant (WINNING_WPORT = 1)
  - a helper function for address-width computation
- One natural sub-module, `regfile_read_port`: per-port address compare, bypass mux and zero-register force. It is instantiated NR times in a generate loop.
- Array storage, write-collision resolution and the clear FSM stay in the top module.

## Test plan
- Reset, DEPTH=32: hold reset 3 cycles, release → busy=1 for exactly 32 edges, then 0. Read of all entries returns 0x0000_0000.
- Write/read: write 0xDEADBEEF to addr 5 via port 0, next cycle raddr[0]=5 → rdata[0]=0xDEADBEEF one cycle later.
- Collision and bypass: same edge, port 0 writes 0x11111111 and port 1 writes 0x22222222 to addr 7, raddr[1]=7 → rdata[1]=0x22222222 immediately. The array holds 0x22222222 on a later read.
- Zero register, ZERO_REG=1: write 0xFFFFFFFF to addr 0 → read addr 0 returns 0 both on the bypass edge and after. With ZERO_REG=0, the same sequence returns 0xFFFFFFFF.
- Mid-clear reset: release reset, reassert at busy cycle 10 for 1 cycle → busy stays high for 32 further edges. A write attempted during busy (addr 3, 0xA5A5A5A5) is dropped, and addr 3 reads 0.
- Multi-port read, NR=4: ports 0–3 read addrs 1, 1, 2, 31 after known writes → each port returns its entry in the same cycle.
